boreal_replay_reader: RTL and testbench

//  Read-side drain engine for the 1024-entry neural telemetry replay ledger.
//  On a host dump request it walks the ledger's synchronous read port from a start address.
//  It serializes each 48-bit record {mu_t, epsilon, hrv_metric} into 6 bytes, MSB first.

---
 rtl/boreal_replay_pkg.sv | 37 +++
 rtl/boreal_record_serializer.sv | 63 ++++++
 rtl/boreal_replay_reader.sv | 195 +++++++++++++++++++
 tb/tb_boreal_replay_reader.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boreal_replay_pkg.sv
// Shared constants, FSM state type and CRC-8 helper for the replay ledger reader.
// Optional trailer CRC is built in when BOREAL_REPLAY_CRC_EN is defined.
package boreal_replay_pkg;

  localparam int unsigned REPLAY_DEPTH  = 1024;
  localparam int unsigned REPLAY_ADDR_W = 10;
  localparam int unsigned REPLAY_REC_W  = 48;

  // Record layout {mu_t, epsilon, hrv_metric}, 16 bits each
  localparam int unsigned MU_MSB  = 47;
  localparam int unsigned EPS_MSB = 31;
  localparam int unsigned HRV_MSB = 15;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StSend,
`ifdef BOREAL_REPLAY_CRC_EN
    StCrc,
`endif
    StDone
  } replay_state_e;

  // MSB-first CRC-8, no reflection, no final xor
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/boreal_record_serializer.sv
// Loads one record into a shift register and emits it MSB byte first on a valid/ready stream.
// Build option BOREAL_REPLAY_CRC_EN reuses this block for the 1-byte CRC trailer.
module boreal_record_serializer
  import boreal_replay_pkg::*;
#(
  parameter int unsigned REC_W = REPLAY_REC_W,
  localparam int unsigned NBYTES = REC_W / 8,
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [REC_W-1:0] load_data,
  input  logic [CNT_W-1:0] load_bytes,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             xfer,
  output logic             last
);

  logic [REC_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic             valid_q, valid_d;

  assign tx_data  = shreg_q[REC_W-1 -: 8];
  assign tx_valid = valid_q;
  assign xfer     = valid_q & tx_ready;
  assign last     = xfer && (left_q == CNT_W'(1));

  always_comb begin
    shreg_d = shreg_q;
    left_d  = left_q;
    valid_d = valid_q;
    if (clear) begin
      shreg_d = '0;
      left_d  = '0;
      valid_d = 1'b0;
    end else if (load) begin
      shreg_d = load_data;
      left_d  = load_bytes;
      valid_d = (load_bytes != '0);
    end else if (xfer) begin
      shreg_d = shreg_q << 8;
      left_d  = left_q - CNT_W'(1);
      valid_d = (left_q != CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      left_q  <= left_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/boreal_replay_reader.sv
// Drains the replay ledger from a start address as a byte stream, one record at a time.
// Defining BOREAL_REPLAY_CRC_EN appends a CRC-8 trailer byte to every dump.
module boreal_replay_reader
  import boreal_replay_pkg::*;
#(
  parameter int unsigned DEPTH      = REPLAY_DEPTH,
  parameter int unsigned ADDR_W     = REPLAY_ADDR_W,
  parameter int unsigned REC_W      = REPLAY_REC_W,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_req,
  input  logic [ADDR_W-1:0] dump_start_addr,
  input  logic [ADDR_W:0]   dump_count,
  input  logic              dump_abort,
  output logic              busy,
  output logic              dump_done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [REC_W-1:0]  rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int unsigned NBYTES = REC_W / 8;
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

  replay_state_e     state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [1:0]        wait_q, wait_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   count_clamped;

  logic              ser_clear, ser_load, ser_xfer, ser_last;
  logic [REC_W-1:0]  ser_data;
  logic [CNT_W-1:0]  ser_bytes;

`ifdef BOREAL_REPLAY_CRC_EN
  logic [7:0] crc_q, crc_d;
`endif

  assign busy      = busy_q;
  assign dump_done = done_q;
  assign rd_addr   = rd_addr_q;

  assign count_clamped = (dump_count > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : dump_count;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ser_clear   = 1'b0;
    ser_load    = 1'b0;
    ser_data    = rd_data;
    ser_bytes   = CNT_W'(NBYTES);
`ifdef BOREAL_REPLAY_CRC_EN
    crc_d       = crc_q;
`endif

    case (state_q)
      StIdle: begin
        // An abort in the same cycle cancels the request outright
        if (dump_req && !dump_abort) begin
          busy_d      = 1'b1;
          remaining_d = count_clamped;
`ifdef BOREAL_REPLAY_CRC_EN
          crc_d       = 8'h00;
`endif
          if (count_clamped == '0) begin
`ifdef BOREAL_REPLAY_CRC_EN
            state_d   = StCrc;
            ser_load  = 1'b1;
            ser_data  = '0;
            ser_bytes = CNT_W'(1);
`else
            state_d   = StDone;
`endif
          end else begin
            rd_addr_d = dump_start_addr;
            wait_d    = 2'd0;
            state_d   = StFetch;
          end
        end
      end
      StFetch: begin
        if (wait_q == 2'(RD_LATENCY - 1)) begin
          state_d = StLatch;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      StLatch: begin
        ser_load = 1'b1;
        state_d  = StSend;
      end
      StSend: begin
`ifdef BOREAL_REPLAY_CRC_EN
        if (ser_xfer) begin
          crc_d = crc8_update(crc_q, tx_data);
        end
`endif
        if (ser_last) begin
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          if (remaining_q > (ADDR_W+1)'(1)) begin
            rd_addr_d = (rd_addr_q == ADDR_W'(DEPTH - 1)) ? '0 : rd_addr_q + ADDR_W'(1);
            wait_d    = 2'd0;
            state_d   = StFetch;
          end else begin
`ifdef BOREAL_REPLAY_CRC_EN
            // Trailer carries the CRC including the byte leaving this cycle
            state_d   = StCrc;
            ser_load  = 1'b1;
            ser_data  = '0;
            ser_data[REC_W-1 -: 8] = crc_d;
            ser_bytes = CNT_W'(1);
`else
            state_d   = StDone;
`endif
          end
        end
      end
`ifdef BOREAL_REPLAY_CRC_EN
      StCrc: begin
        if (ser_last) begin
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    if (dump_abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      ser_clear = 1'b1;
      ser_load  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      remaining_q <= '0;
      wait_q      <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef BOREAL_REPLAY_CRC_EN
      crc_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      remaining_q <= remaining_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef BOREAL_REPLAY_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

  boreal_record_serializer #(
    .REC_W (REC_W)
  ) u_serializer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (ser_clear),
    .load       (ser_load),
    .load_data  (ser_data),
    .load_bytes (ser_bytes),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .xfer       (ser_xfer),
    .last       (ser_last)
  );

endmodule

// File: tb/tb_boreal_replay_reader.sv
// Scoreboard bench for boreal_replay_reader with a 1-cycle behavioural ledger.
// Expectations adapt to BOREAL_REPLAY_CRC_EN when the bundle is built with it.
module tb_boreal_replay_reader;

`ifdef BOREAL_REPLAY_CRC_EN
  localparam int CRC_EXTRA = 1;
`else
  localparam int CRC_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dump_req = 1'b0;
  logic [9:0]  dump_start_addr = '0;
  logic [10:0] dump_count = '0;
  logic        dump_abort = 1'b0;
  logic        busy, dump_done;
  logic [9:0]  rd_addr;
  logic [47:0] rd_data = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;

  logic [47:0] mem [1024];

  int n_checks = 0;
  int n_bad = 0;
  int rx_count = 0;
  int done_cnt = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_crc = 8'h00;
  logic [9:0] addr_q [$];
  logic [9:0] prev_addr = '0;
  logic       track_en = 1'b0;

  logic [7:0] t1_exp [12] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h5A, 8'h5A,
                              8'h00, 8'h01, 8'hFF, 8'hFE, 8'h5A, 8'h5B};
  logic [7:0] t4_exp [6]  = '{8'h00, 8'h05, 8'hFF, 8'hFA, 8'h5A, 8'h5F};
  logic [9:0] t2_addr [4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};

  boreal_replay_reader u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dump_req        (dump_req),
    .dump_start_addr (dump_start_addr),
    .dump_count      (dump_count),
    .dump_abort      (dump_abort),
    .busy            (busy),
    .dump_done       (dump_done),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Bitwise-serial CRC-8 reference (poly 0x07)
  function automatic logic [7:0] crc_ref(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    logic fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ b[i];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(b);
    exp_crc = crc_ref(exp_crc, b);
  endtask

  task automatic push_rec(input int addr);
    logic [47:0] rec;
    rec = mem[addr % 1024];
    for (int k = 0; k < 6; k++) push_byte(rec[47-8*k -: 8]);
  endtask

  task automatic push_trailer();
`ifdef BOREAL_REPLAY_CRC_EN
    exp_q.push_back(exp_crc);
`endif
  endtask

  task automatic start_dump(input logic [9:0] start, input logic [10:0] count);
    @(posedge clk); #1;
    dump_req = 1'b1;
    dump_start_addr = start;
    dump_count = count;
    @(posedge clk); #1;
    dump_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt < target) begin
      n_checks++;
      n_bad++;
      $display("FAIL %s_timeout: done_cnt %0d expected %0d", name, done_cnt, target);
    end
  endtask

  // Monitor: scoreboard pop, stall stability and event counting
  initial begin
    logic       stall_pending;
    logic [7:0] stall_byte;
    stall_pending = 1'b0;
    stall_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stall_pending) begin
          check("stall_valid", 32'(tx_valid), 32'd1);
          check("stall_data", 32'(tx_data), 32'(stall_byte));
        end
        if (tx_valid && !tx_ready && !dump_abort) begin
          stall_pending = 1'b1;
          stall_byte = tx_data;
        end else begin
          stall_pending = 1'b0;
        end
        if (tx_valid && tx_ready) begin
          rx_count++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_bad++;
            $display("FAIL unexpected_byte: got %0h expected none", tx_data);
          end else begin
            check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
          end
        end
        if (dump_done) done_cnt++;
        if (track_en && rd_addr != prev_addr) begin
          addr_q.push_back(rd_addr);
          prev_addr = rd_addr;
        end
      end else begin
        stall_pending = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_rx, base_done, n;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = {16'(i), ~16'(i), 16'(i) ^ 16'h5A5A};
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(dump_done), 32'd0);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_addr", 32'(rd_addr), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;

    // 1: two records from 0
    base_rx = rx_count; base_done = done_cnt; exp_crc = 8'h00;
    for (int k = 0; k < 12; k++) push_byte(t1_exp[k]);
    push_trailer();
    start_dump(10'd0, 11'd2);
    wait_done(base_done + 1, 200, "t1");
    check("t1_bytes", 32'(rx_count - base_rx), 32'(12 + CRC_EXTRA));
    check("t1_done_cnt", 32'(done_cnt - base_done), 32'd1);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_done_width", 32'(dump_done), 32'd0);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // 2: address wrap
    base_rx = rx_count; base_done = done_cnt; exp_crc = 8'h00;
    addr_q.delete(); prev_addr = rd_addr; track_en = 1'b1;
    push_rec(1022); push_rec(1023); push_rec(0); push_rec(1);
    push_trailer();
    start_dump(10'd1022, 11'd4);
    wait_done(base_done + 1, 300, "t2");
    track_en = 1'b0;
    check("t2_bytes", 32'(rx_count - base_rx), 32'(24 + CRC_EXTRA));
    check("t2_addr_cnt", 32'(addr_q.size()), 32'd4);
    if (addr_q.size() == 4) begin
      for (int k = 0; k < 4; k++) check("t2_addr", 32'(addr_q[k]), 32'(t2_addr[k]));
    end

    // 3: backpressure
    base_rx = rx_count; base_done = done_cnt; exp_crc = 8'h00;
    tx_ready = 1'b0;
    push_rec(7); push_trailer();
    start_dump(10'd7, 11'd1);
    repeat (20) begin @(posedge clk); #1; end
    check("t3_valid_stalled", 32'(tx_valid), 32'd1);
    check("t3_no_xfer_stalled", 32'(rx_count - base_rx), 32'd0);
    for (int i = 0; i < 400 && done_cnt < base_done + 1; i++) begin
      tx_ready = ~tx_ready;
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    check("t3_done", 32'(done_cnt - base_done), 32'd1);
    check("t3_bytes", 32'(rx_count - base_rx), 32'(6 + CRC_EXTRA));

    // 4: abort after 3rd byte of record 1, then a fresh dump
    base_rx = rx_count; base_done = done_cnt; exp_crc = 8'h00;
    push_rec(10);
    for (int k = 0; k < 3; k++) exp_q.push_back(mem[11][47-8*k -: 8]);
    start_dump(10'd10, 11'd3);
    n = 0;
    while ((rx_count - base_rx) < 9 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("t4_reach_abort", 32'(rx_count - base_rx), 32'd9);
    tx_ready = 1'b0;
    dump_abort = 1'b1;
    @(posedge clk); #1;
    dump_abort = 1'b0;
    check("t4_valid_abort", 32'(tx_valid), 32'd0);
    check("t4_busy_abort", 32'(busy), 32'd0);
    repeat (10) begin @(posedge clk); #1; end
    check("t4_no_done", 32'(done_cnt - base_done), 32'd0);
    check("t4_bytes", 32'(rx_count - base_rx), 32'd9);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
    tx_ready = 1'b1;
    base_rx = rx_count; base_done = done_cnt; exp_crc = 8'h00;
    for (int k = 0; k < 6; k++) push_byte(t4_exp[k]);
    push_trailer();
    start_dump(10'd5, 11'd1);
    wait_done(base_done + 1, 100, "t4b");
    check("t4b_bytes", 32'(rx_count - base_rx), 32'(6 + CRC_EXTRA));
    // Abort coincident with request cancels it
    @(posedge clk); #1;
    dump_req = 1'b1; dump_abort = 1'b1; dump_start_addr = 10'd3; dump_count = 11'd1;
    @(posedge clk); #1;
    dump_req = 1'b0; dump_abort = 1'b0;
    check("t4c_cancel_busy", 32'(busy), 32'd0);
    repeat (12) begin @(posedge clk); #1; end
    check("t4c_cancel_bytes", 32'(rx_count - base_rx), 32'(6 + CRC_EXTRA));

    // 5a: empty dump
    base_rx = rx_count; base_done = done_cnt; exp_crc = 8'h00;
    push_trailer();
`ifdef BOREAL_REPLAY_CRC_EN
    start_dump(10'd0, 11'd0);
    wait_done(base_done + 1, 50, "t5a");
`else
    start_dump(10'd0, 11'd0);
    check("t5a_busy_c1", 32'(busy), 32'd1);
    check("t5a_done_c1", 32'(dump_done), 32'd0);
    @(posedge clk); #1;
    check("t5a_busy_c2", 32'(busy), 32'd0);
    check("t5a_done_c2", 32'(dump_done), 32'd1);
    @(posedge clk); #1;
    check("t5a_done_c3", 32'(dump_done), 32'd0);
`endif
    repeat (3) begin @(posedge clk); #1; end
    check("t5a_bytes", 32'(rx_count - base_rx), 32'(CRC_EXTRA));
    check("t5a_done_cnt", 32'(done_cnt - base_done), 32'd1);

    // 5b: oversized count clamps to a full ledger pass; req while busy ignored
    base_rx = rx_count; base_done = done_cnt; exp_crc = 8'h00;
    for (int i = 0; i < 1024; i++) push_rec(100 + i);
    push_trailer();
    start_dump(10'd100, 11'd2000);
    repeat (50) begin @(posedge clk); #1; end
    start_dump(10'd0, 11'd5);
    wait_done(base_done + 1, 12000, "t5b");
    check("t5b_bytes", 32'(rx_count - base_rx), 32'(6144 + CRC_EXTRA));
    check("t5b_end_addr", 32'(rd_addr), 32'd99);
    repeat (20) begin @(posedge clk); #1; end
    check("t5b_busy_after", 32'(busy), 32'd0);
    check("t5b_done_cnt", 32'(done_cnt - base_done), 32'd1);
    check("t5b_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef BOREAL_REPLAY_CRC_EN
    // 6: known CRC trailer
    base_rx = rx_count; base_done = done_cnt;
    mem[0] = 48'h0000_0000_0001;
    for (int k = 0; k < 5; k++) exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h07);
    start_dump(10'd0, 11'd1);
    wait_done(base_done + 1, 100, "t6");
    check("t6_bytes", 32'(rx_count - base_rx), 32'd7);
`endif

    // 7: reset mid-SEND
    base_rx = rx_count; base_done = done_cnt; exp_crc = 8'h00;
    push_rec(3); push_rec(4); push_trailer();
    start_dump(10'd3, 11'd2);
    n = 0;
    while ((rx_count - base_rx) < 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t7_mid_send", 32'(rx_count - base_rx), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_done", 32'(dump_done), 32'd0);
    check("t7_rst_valid", 32'(tx_valid), 32'd0);
    check("t7_rst_data", 32'(tx_data), 32'd0);
    check("t7_rst_addr", 32'(rd_addr), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("t7_idle_busy", 32'(busy), 32'd0);
    check("t7_idle_valid", 32'(tx_valid), 32'd0);
    check("t7_no_done", 32'(done_cnt - base_done), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
